// File: rtl/dec_onehot_seq.sv
// dec_onehot_seq: registered AW-to-2^AW decoder with a valid/ready input handshake,
// one-hot / thermometer / inverse one-hot modes and a programmable per-word hold time.
// Each accepted index is driven on Y for HOLD cycles. Back-to-back words need no gap cycle.
module dec_onehot_seq #(
    parameter int unsigned AW        = 5,
    parameter int unsigned HOLD      = 1,
    parameter bit          ZERO_MASK = 1'b0
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              En,
    input  logic              In_Valid,
    output logic              In_Ready,
    input  logic [AW-1:0]     I,
    input  logic [1:0]        Mode,
    output logic [2**AW-1:0]  Y,
    output logic              Y_Valid,
    output logic              Busy,
    output logic              Err
);

    localparam int unsigned NW = 2**AW;
    localparam int unsigned CW = $clog2(HOLD) + 1;
    localparam logic [CW-1:0] LAST = CW'(HOLD - 1);

    typedef enum logic {
        ST_IDLE,
        ST_DRIVE
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [NW-1:0]   r_y;
    logic            r_y_valid;
    logic            r_err;

    logic [NW-1:0]   w_dec;
    logic            w_ready;
    logic            w_xfer;

    // Ready depends only on state, counter and enable so it never loops back through In_Valid.
    always_comb begin
        w_ready = En & ((r_state == ST_IDLE) | ((r_state == ST_DRIVE) & (r_cnt == LAST)));
        w_xfer  = w_ready & In_Valid;
    end

    // Mode decode of the presented index; bit 0 is masked afterwards when ZERO_MASK is set.
    always_comb begin
        w_dec = '0;
        for (int unsigned j = 0; j < NW; j++) begin
            case (Mode)
                2'b00:   w_dec[j] = (AW'(j) == I);
                2'b01:   w_dec[j] = (AW'(j) <= I);
                2'b10:   w_dec[j] = (AW'(j) != I);
                default: w_dec[j] = 1'b0;
            endcase
        end
        if (ZERO_MASK) begin
            w_dec[0] = 1'b0;
        end
    end

    // IDLE/DRIVE sequencer: loads a word on transfer, holds it HOLD cycles, clears on En=0.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_y       <= '0;
            r_y_valid <= 1'b0;
            r_err     <= 1'b0;
        end else if (!En) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_y       <= '0;
            r_y_valid <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_err <= 1'b0;
            if (w_xfer) begin
                r_state   <= ST_DRIVE;
                r_cnt     <= '0;
                r_y       <= w_dec;
                r_y_valid <= 1'b1;
                r_err     <= (Mode == 2'b11);
            end else if (r_state == ST_DRIVE) begin
                if (r_cnt != LAST) begin
                    r_cnt <= r_cnt + 1'b1;
                end else begin
                    r_state   <= ST_IDLE;
                    r_cnt     <= '0;
                    r_y       <= '0;
                    r_y_valid <= 1'b0;
                end
            end
        end
    end

    assign In_Ready = w_ready;
    assign Y        = r_y;
    assign Y_Valid  = r_y_valid;
    assign Busy     = (r_state == ST_DRIVE);
    assign Err      = r_err;

endmodule

// File: tb/tb_dec_onehot_seq.sv
// Bench for dec_onehot_seq: three configurations (HOLD=1, HOLD=3 with ZERO_MASK, HOLD=4),
// each with its own stimulus process, expected-word queue and negedge monitor.
module tb_dec_onehot_seq;

    typedef struct packed {
        logic [31:0] y;
        logic        err;
    } exp_t;

    logic        clk;
    int unsigned n_cmp;
    int unsigned n_bad;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected word from the decode rules using plain shift arithmetic.
    function automatic logic [31:0] ref_word(input logic [4:0] i, input logic [1:0] m, input bit zm);
        logic [63:0] one;
        logic [63:0] thermo;
        logic [31:0] w;
        one    = 64'd1 << i;
        thermo = (one << 1) - 64'd1;
        case (m)
            2'd0:    w = one[31:0];
            2'd1:    w = thermo[31:0];
            2'd2:    w = ~one[31:0];
            default: w = 32'd0;
        endcase
        if (zm) w = w & ~32'd1;
        return w;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_cfg
        localparam int unsigned H  = (g == 0) ? 1 : ((g == 1) ? 3 : 4);
        localparam bit          ZM = (g == 1);

        logic        rst, en, in_valid, in_ready, y_valid, busy, err;
        logic [4:0]  idx;
        logic [1:0]  mode;
        logic [31:0] y;
        exp_t        q[$];
        bit          done;

        dec_onehot_seq #(.AW(5), .HOLD(H), .ZERO_MASK(ZM)) u_dut (
            .Clk      (clk),
            .Rst      (rst),
            .En       (en),
            .In_Valid (in_valid),
            .In_Ready (in_ready),
            .I        (idx),
            .Mode     (mode),
            .Y        (y),
            .Y_Valid  (y_valid),
            .Busy     (busy),
            .Err      (err)
        );

        // Monitor: each live cycle consumes one queued word; an empty queue means idle outputs.
        always @(negedge clk) begin : monitor
            exp_t e;
            logic exp_rdy;
            exp_rdy = en && (q.size() <= 1);
            chk($sformatf("cfg%0d In_Ready", g), 32'(in_ready), 32'(exp_rdy));
            if (q.size() > 0) begin
                e = q.pop_front();
                chk($sformatf("cfg%0d Y", g), y, e.y);
                chk($sformatf("cfg%0d Err", g), 32'(err), 32'(e.err));
                chk($sformatf("cfg%0d Y_Valid", g), 32'(y_valid), 32'd1);
                chk($sformatf("cfg%0d Busy", g), 32'(busy), 32'd1);
            end else begin
                chk($sformatf("cfg%0d idle Y", g), y, 32'd0);
                chk($sformatf("cfg%0d idle Err", g), 32'(err), 32'd0);
                chk($sformatf("cfg%0d idle Y_Valid", g), 32'(y_valid), 32'd0);
                chk($sformatf("cfg%0d idle Busy", g), 32'(busy), 32'd0);
            end
        end

        task automatic cycle(input bit c_en, input bit c_valid, input logic [4:0] c_i,
                             input logic [1:0] c_m, output bit taken);
            @(negedge clk);
            #1;
            en       = c_en;
            in_valid = c_valid;
            idx      = c_i;
            mode     = c_m;
            #3;
            taken = 1'b0;
            if (!en) begin
                q.delete();
            end else if (in_valid && q.size() == 0) begin
                taken = 1'b1;
                for (int unsigned k = 0; k < H; k++) begin
                    exp_t e;
                    e.y   = ref_word(idx, mode, ZM);
                    e.err = (k == 0) && (mode == 2'b11);
                    q.push_back(e);
                end
            end
        endtask

        task automatic send(input logic [4:0] s_i, input logic [1:0] s_m);
            bit t;
            int unsigned n;
            n = 0;
            do begin
                cycle(1'b1, 1'b1, s_i, s_m, t);
                n++;
            end while (!t && n < H + 2);
            if (!t) begin
                n_cmp++;
                n_bad++;
                $display("FAIL cfg%0d send timeout: got no acceptance expected acceptance", g);
            end
        endtask

        task automatic idle(input int unsigned n);
            bit t;
            repeat (n) cycle(1'b1, 1'b0, 5'd0, 2'd0, t);
        endtask

        initial begin : stim
            bit t;
            done     = 1'b0;
            rst      = 1'b1;
            en       = 1'b0;
            in_valid = 1'b0;
            idx      = '0;
            mode     = '0;
            repeat (2) @(negedge clk);
            #1 rst = 1'b0;

            for (int i = 0; i < 32; i++) send(5'(i), 2'd0);
            idle(H + 1);
            send(5'd7, 2'd1);
            idle(H + 1);
            send(5'd4, 2'd2);
            send(5'd0, 2'd0);
            idle(H + 1);
            send(5'd9, 2'd3);
            idle(H + 1);

            // enable dropped while a word is live (at cnt=1 when HOLD allows)
            send(5'd5, 2'd0);
            if (H > 1) cycle(1'b1, 1'b0, 5'd0, 2'd0, t);
            cycle(1'b0, 1'b1, 5'd6, 2'd0, t);
            cycle(1'b0, 1'b0, 5'd0, 2'd0, t);
            send(5'd6, 2'd1);
            idle(H + 1);

            // asynchronous reset in the middle of a live word
            send(5'd12, 2'd0);
            @(negedge clk);
            #1 rst = 1'b1;
            #1;
            chk($sformatf("cfg%0d async Y", g), y, 32'd0);
            chk($sformatf("cfg%0d async Y_Valid", g), 32'(y_valid), 32'd0);
            chk($sformatf("cfg%0d async Busy", g), 32'(busy), 32'd0);
            chk($sformatf("cfg%0d async Err", g), 32'(err), 32'd0);
            q.delete();
            in_valid = 1'b0;
            @(negedge clk);
            #1 rst = 1'b0;
            send(5'd20, 2'd1);
            idle(H + 1);

            repeat (300) begin
                cycle(($urandom % 12) != 0, ($urandom % 3) != 0, 5'($urandom), 2'($urandom), t);
            end
            idle(H + 2);
            done = 1'b1;
        end
    end

    initial begin
        int unsigned n;
        n_cmp = 0;
        n_bad = 0;
        n = 0;
        while (!(g_cfg[0].done && g_cfg[1].done && g_cfg[2].done) && n < 20000) begin
            @(posedge clk);
            n++;
        end
        if (!(g_cfg[0].done && g_cfg[1].done && g_cfg[2].done)) begin
            n_cmp++;
            n_bad++;
            $display("FAIL run timeout: got unfinished stimulus expected completion");
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
